// File: rtl/ft_axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Contents:
//   clog2       - constant function that sizes address fields from DEPTH
//   ft_entry_t  - layout of one stored beat {tlast, tkeep, tdata} at the default 64-bit width
//   LED_*       - bit positions inside leds_4bits_tri_o
package ft_axis_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_TDATA_WIDTH = 64;
  localparam int DEF_TDATA_BYTES = 8;

  // The top level declares the same field order at its own parameterised widths.
  typedef struct packed {
    logic                       tlast;
    logic [DEF_TDATA_BYTES-1:0] tkeep;
    logic [DEF_TDATA_WIDTH-1:0] tdata;
  } ft_entry_t;

  localparam int LED_FULL   = 3;
  localparam int LED_EMPTY  = 2;
  localparam int LED_TOGGLE = 1;
  localparam int LED_FORCED = 0;

endpackage

// File: rtl/ft_sync_fifo_mem.sv
// Register-array storage for the packet FIFO: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data follows i_rd_addr combinationally.
// Backpressure: none here, the caller gates i_wr_en.
//
// Ports:
//   i_clk      - write clock
//   i_wr_en    - write strobe
//   i_wr_addr  - write address
//   i_wr_dat   - write data
//   i_rd_addr  - read address
//   o_rd_dat   - read data (combinational)
module ft_sync_fifo_mem
  import ft_axis_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 73,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_dat,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_dat
);

  // Contents are deliberately left unreset; the pointers define what is valid.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/ft_axis_pkt_fifo.sv
// AXI-Stream FIFO with tkeep byte masking, optional store-and-forward packet mode and debug status.
// Latency: 1 cycle from ingress accept to egress valid; no same-cycle bypass; first-word fall-through.
// Backpressure: s_axis_tready drops only when full; egress holds its beat while tvalid & ~tready.
//
// Ports:
//   s_axis_aclk / s_axis_aresetn       - clock, asynchronous active-low reset
//   s_axis_t{data,keep,last,valid,ready} - ingress stream
//   m_axis_t{data,keep,last,valid,ready} - egress stream (masked bytes read back as zero)
//   fill_level                          - beats stored, 0..DEPTH
//   pkt_count                           - tlast beats delivered on egress, wrapping
//   leds_4bits_tri_o                    - {full, empty, tlast_toggle, forced_release}
module ft_axis_pkt_fifo
  import ft_axis_pkg::*;
#(
  parameter  int TDATA_WIDTH = 64,
  parameter  int TDATA_BYTES = 8,
  parameter  int DEPTH       = 16,
  parameter  int PACKET_MODE = 0,
  parameter  int KEEP_PASS   = 1,
  parameter  int CNT_W       = 16,
  localparam int ADDR_W      = clog2(DEPTH)
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_aresetn,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TDATA_BYTES-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TDATA_BYTES-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [ADDR_W:0]        fill_level,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [3:0]             leds_4bits_tri_o
);

  typedef struct packed {
    logic                   tlast;
    logic [TDATA_BYTES-1:0] tkeep;
    logic [TDATA_WIDTH-1:0] tdata;
  } entry_t;

  localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic [ADDR_W:0]  r_stored_pkts;
  logic [CNT_W-1:0] r_pkt_count;
  logic             r_run;
  logic             r_forced;
  logic             r_toggle;

  logic   w_empty;
  logic   w_full;
  logic   w_wr;
  logic   w_rd;
  logic   w_release;
  entry_t w_wr_ent;
  entry_t w_rd_ent;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // r_run holds the ports quiet until the first edge after reset is released.
  assign s_axis_tready = r_run & ~w_full;
  assign w_wr          = s_axis_tvalid & s_axis_tready;

  // Store-and-forward releases only once a complete packet is held, or once an
  // oversize packet has filled the buffer and must drain cut-through.
  assign w_release     = (PACKET_MODE == 0) ? 1'b1 : ((r_stored_pkts != '0) | r_forced);
  assign m_axis_tvalid = r_run & ~w_empty & w_release;
  assign w_rd          = m_axis_tvalid & m_axis_tready;

  always_comb begin
    w_wr_ent       = '0;
    w_wr_ent.tlast = s_axis_tlast;
    w_wr_ent.tkeep = s_axis_tkeep;
    for (int i = 0; i < TDATA_BYTES; i++) begin
      w_wr_ent.tdata[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
    end
  end

  ft_sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (TDATA_WIDTH + TDATA_BYTES + 1)
  ) u_mem (
    .i_clk     (s_axis_aclk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_dat  (w_wr_ent),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_dat  (w_rd_ent)
  );

  assign m_axis_tdata = w_rd_ent.tdata;
  assign m_axis_tkeep = (KEEP_PASS != 0) ? w_rd_ent.tkeep : {TDATA_BYTES{1'b1}};
  assign m_axis_tlast = w_rd_ent.tlast;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_run         <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_stored_pkts <= '0;
      r_pkt_count   <= '0;
      r_forced      <= 1'b0;
      r_toggle      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_rd && w_rd_ent.tlast) begin
        r_pkt_count <= r_pkt_count + CNT_ONE;
        r_toggle    <= ~r_toggle;
      end
      if (PACKET_MODE != 0) begin
        case ({w_wr && s_axis_tlast, w_rd && w_rd_ent.tlast})
          2'b10:   r_stored_pkts <= r_stored_pkts + PTR_ONE;
          2'b01:   r_stored_pkts <= r_stored_pkts - PTR_ONE;
          default: r_stored_pkts <= r_stored_pkts;
        endcase
        // Full with no complete packet inside can only be an oversize packet.
        if (w_rd && w_rd_ent.tlast) r_forced <= 1'b0;
        else if (w_full && (r_stored_pkts == '0)) r_forced <= 1'b1;
      end
    end
  end

  assign fill_level = r_wr_ptr - r_rd_ptr;
  assign pkt_count  = r_pkt_count;

  always_comb begin
    leds_4bits_tri_o             = '0;
    leds_4bits_tri_o[LED_FULL]   = w_full;
    leds_4bits_tri_o[LED_EMPTY]  = w_empty;
    leds_4bits_tri_o[LED_TOGGLE] = r_toggle;
    leds_4bits_tri_o[LED_FORCED] = r_forced;
  end

endmodule
